// File: rtl/dbus_mem_slave.sv
// Word-addressed RAM responder for the core bus.
// Each request is answered after LATENCY wait states; out-of-range accesses are flagged.
module dbus_mem_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
  parameter int                    LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_bus_req,
  input  logic                  I_bus_we,
  input  logic [ADDR_WIDTH-1:0] I_bus_addr,
  input  logic [DATA_WIDTH-1:0] I_bus_data,
  input  logic [3:0]            I_bus_mask,
  output logic [DATA_WIDTH-1:0] O_bus_data,
  output logic                  O_bus_ready,
  output logic                  O_bus_err
);

  // state  | meaning
  // S_IDLE | no transaction; waiting for I_bus_req
  // S_WAIT | request latched; cnt counts down the wait states, access at cnt=0
  // S_RESP | one-cycle response strobe; may accept the next request
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH);

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              mask_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    accept;
  logic                    access;

  // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE land far out of range.
  assign offset   = addr_q - BASE;
  assign in_range = offset < SPAN;
  assign idx      = offset[IDX_W+1:2];
  assign accept   = I_bus_req && (state == S_IDLE || state == S_RESP);
  assign access   = (state == S_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (I_bus_req) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = I_bus_req ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    O_bus_ready = (state == S_RESP);
    O_bus_err   = (state == S_RESP) && err_q;
    O_bus_data  = rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY);
        we_q    <= I_bus_we;
        addr_q  <= I_bus_addr;
        wdata_q <= I_bus_data;
        mask_q  <= I_bus_mask;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= !in_range;
        if (!we_q) rdata_q <= in_range ? mem[idx] : ERR_DATA;
      end
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (access && we_q && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem_slave.sv
// Scoreboard bench for dbus_mem_slave: port 0 runs LATENCY=2, port 1 runs LATENCY=0.
// Expected responses come from a word-array memory model and are checked by a negedge monitor.
module tb_dbus_mem_slave;
  localparam logic [31:0] BASE_A = 32'h8000_0000;
  localparam logic [31:0] ERR_D  = 32'hDEAD_BEEF;
  localparam int          DEPTH  = 1024;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req, we, rdy, err;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  mask  [2];
  logic [31:0] rdata [2];

  int   cyc = 0;
  int   n_chk = 0, n_pass = 0, n_to = 0;
  bit   done = 1'b0;
  bit   prev_rdy [2];
  exp_t q0 [$];
  exp_t q1 [$];

  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_mem_slave #(.LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .I_bus_req(req[0]), .I_bus_we(we[0]), .I_bus_addr(addr[0]),
    .I_bus_data(wdata[0]), .I_bus_mask(mask[0]),
    .O_bus_data(rdata[0]), .O_bus_ready(rdy[0]), .O_bus_err(err[0])
  );

  dbus_mem_slave #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .I_bus_req(req[1]), .I_bus_we(we[1]), .I_bus_addr(addr[1]),
    .I_bus_data(wdata[1]), .I_bus_mask(mask[1]),
    .O_bus_data(rdata[1]), .O_bus_ready(rdy[1]), .O_bus_err(err[1])
  );

  // Monitor: owns all pass/check counters and prints the summary.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_chk++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL drain: pending responses port0=%0d port1=%0d required=0", q0.size(), q1.size());
      n_chk += n_to;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
    for (int p = 0; p < 2; p++) begin
      if (!rst) begin
        n_chk++;
        if (rdy[p] === 1'b0 && err[p] === 1'b0 && rdata[p] === 32'h0) n_pass++;
        else $display("FAIL reset_state port%0d: ready=%b err=%b data=%h required 0/0/00000000",
                      p, rdy[p], err[p], rdata[p]);
      end else begin
        if (err[p] && !rdy[p]) begin
          n_chk++;
          $display("FAIL err_without_ready port%0d: err=1 required=0", p);
        end
        if (rdy[p] && prev_rdy[p]) begin
          n_chk++;
          $display("FAIL ready_consecutive port%0d: ready high two cycles, required single pulse", p);
        end
        if (rdy[p]) begin
          n_chk++;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            $display("FAIL unexpected_ready port%0d at cycle %0d: no response expected", p, cyc);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            if (cyc == e.cyc && rdata[p] === e.data && err[p] === e.err) n_pass++;
            else $display("FAIL response port%0d: cycle=%0d data=%h err=%b required cycle=%0d data=%h err=%b",
                          p, cyc, rdata[p], err[p], e.cyc, e.data, e.err);
          end
        end
      end
      prev_rdy[p] = rdy[p] && rst;
    end
  end

  function automatic logic [31:0] rand_addr();
    int          s;
    logic [31:0] a;
    s = $urandom_range(9);
    if (s < 6)       a = BASE_A + 32'(4 * $urandom_range(7));
    else if (s < 8)  a = BASE_A + 32'(4 * (DEPTH - 8 + $urandom_range(7)));
    else if (s == 8) a = $urandom_range(1) ? BASE_A - 32'd4 : BASE_A + 32'(4 * DEPTH);
    else begin
      a = $urandom();
      if ((a - BASE_A) < 32'(4 * DEPTH)) a = BASE_A - 32'd8;
    end
    return a | 32'($urandom_range(3));
  endfunction

  // Called at a negedge when the DUT will accept on the next rising edge.
  // Returns at the negedge inside the response cycle.
  task automatic issue(input int p, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    exp_t        e;
    logic [31:0] off;
    int          idx;
    int          t;
    off   = a - BASE_A;
    e.err = !(off < 32'(4 * DEPTH));
    idx   = int'(off >> 2);
    e.cyc = cyc + 1 + ((p == 0) ? 2 : 0) + 1;
    if (!w) last_rd[p] = e.err ? ERR_D : ref_mem[p][idx];
    else if (!e.err)
      for (int i = 0; i < 4; i++) if (m[i]) ref_mem[p][idx][8*i +: 8] = d[8*i +: 8];
    e.data = last_rd[p];
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; mask[p] = m;
    @(negedge clk);
    // Fields are don't-care after acceptance; req may drop without cancelling.
    we[p] = 1'($urandom_range(1)); addr[p] = $urandom(); wdata[p] = $urandom();
    mask[p] = 4'($urandom_range(15));
    if ($urandom_range(3) == 0) req[p] = 1'b0;
    t = 0;
    while (!rdy[p] && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[p]) begin
      n_to++;
      $display("FAIL timeout port%0d: ready=0 required=1", p);
    end
  endtask

  task automatic idle(input int p, input int gap);
    req[p] = 1'b0;
    repeat (1 + gap) @(negedge clk);
  endtask

  initial begin
    req = 2'b00; we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; mask[p] = '0; last_rd[p] = '0; prev_rdy[p] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Fill the word pool used by every later read.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        issue(p, 1'b1, BASE_A + 32'(4 * ((i < 8) ? i : DEPTH - 16 + i)), $urandom(), 4'hF);
        idle(p, 0);
      end
    end

    issue(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);  idle(0, 1);
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);          idle(0, 0);
    issue(0, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0101); idle(0, 0);
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);          idle(0, 0);
    issue(0, 1'b1, 32'h8000_0010, 32'h5555_AAAA, 4'h0);  idle(0, 0);
    issue(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0);          idle(0, 0);
    issue(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF);          idle(0, 0);
    issue(0, 1'b1, BASE_A + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF); idle(0, 0);
    issue(0, 1'b1, 32'h8000_0010, 32'h0, 4'h0);          idle(0, 0);
    issue(0, 1'b0, BASE_A, 32'h0, 4'h0);                 idle(0, 0);
    issue(0, 1'b0, BASE_A + 32'(4 * DEPTH - 4), 32'h0, 4'h0); idle(0, 0);

    // Back-to-back on the zero-latency port.
    issue(1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF);
    issue(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
    issue(1, 1'b1, 32'h8000_0008, 32'h0BAD_0BAD, 4'b1010);
    issue(1, 1'b0, 32'h8000_0008, 32'h0, 4'hF);
    idle(1, 1);

    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 120; n++) begin
        issue(p, 1'($urandom_range(1)), rand_addr(), $urandom(), 4'($urandom_range(15)));
        if ($urandom_range(1) != 0) idle(p, $urandom_range(2));
      end
      idle(p, 1);
    end

    // Abort a write in WAIT: no response, RAM keeps the old word, outputs reset.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8000_0010;
    wdata[0] = ~ref_mem[0][4]; mask[0] = 4'hF;
    @(negedge clk);
    #1 rst = 1'b0;
    req[0] = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0); idle(0, 0);
    issue(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0); idle(1, 0);

    repeat (4) @(negedge clk);
    #1 done = 1'b1;
    repeat (3) @(negedge clk);
    $display("FAIL summary: monitor did not finish");
    $fatal(1);
  end
endmodule
